memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Producer side of the memory-to-writeback pipeline register.
- Takes the latched execute-to-memory contents and runs the load/store on the data bus using a req/ready handshake.
- Aligns and extends load data, then writes pc, halt, rd, reg_wr_src, alu_out and dload into the writeback latch.
- Stalls the pipeline while the bus is busy, and converts misaligned or timed-out accesses into a halting instruction.

Parameters:
BUS_TIMEOUT, 255, cycles spent waiting in WAIT before the access is abandoned; 0 disables the timeout.

Ports:
clk  in  1  clock; reset is synchronous and active-high
rst  in  1  synchronous, active-high reset
ex_pc  in  32  instruction PC
ex_halt  in  1  halt flag from control unit
ex_rd  in  5  destination register
ex_reg_wr_src  in  2  0 alu, 1 memory, 2 pc+4
ex_alu_out  in  32  ALU result, also the effective address
ex_mem_rd  in  1  load
ex_mem_wr  in  1  store
ex_mem_size  in  2  0 byte, 1 half, 2 word
ex_mem_unsigned  in  1  zero-extend load
ex_store_data  in  32  rs2 value
wb_en  in  1  writeback latch enable from hazard unit
wb_flush  in  1  writeback latch flush
dbus_req  out  1  access request
dbus_wen  out  1  1 = write
dbus_addr  out  32  word-aligned address ({alu_out[31:2],2'b00})
dbus_wdata  out  32  lane-replicated store data
dbus_strb  out  4  byte strobes
dbus_ready  in  1  access complete this cycle
dbus_rdata  in  32  read data, valid when ready
mem_stall  out  1  hold upstream stages
mem_fault  out  1  one-cycle pulse on misalign or timeout
wb_pc, wb_halt, wb_rd, wb_reg_wr_src, wb_alu_out, wb_dload  out  32/1/5/2/32/32  writeback latch

Behaviour:
- Reset: every wb_* output is 0, FSM is IDLE, timeout counter is 0, hold register is 0. dbus_req and mem_fault read 0 in the cycle after reset. Reset asserted during WAIT drops dbus_req the next cycle.
- access = ex_mem_rd | ex_mem_wr. If both are set, treat it as a load.
- misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
- FSM IDLE:
  - Aligned access: dbus_req=1 combinationally.
  - dbus_ready in the same cycle is a zero-wait completion.
  - Otherwise go to WAIT with mem_stall=1.
- FSM WAIT:
  - Hold dbus_req and dbus_addr/wen/wdata/strb stable. Upstream is stalled, so the inputs stay stable.
  - Counter increments each cycle.
  - On dbus_ready, complete and return to IDLE.
  - If the counter reaches BUS_TIMEOUT with no ready: drop dbus_req, pulse mem_fault, complete with dload=0 and halt forced to 1.
- FSM HOLD:
  - Entered when the access completes but wb_en=0. Load data is kept in the hold register.
  - No new request is issued, and mem_stall stays 0 for the completion.
  - Exit to IDLE on the first wb_en=1 cycle, when the latch takes the held dload.
  - Guarantees no access is ever issued twice.
- mem_stall = access & aligned & !completing. mem_stall is 0 in HOLD and for non-memory instructions.
- Misaligned access: no bus request. mem_fault pulses for 1 cycle, and the latch captures halt=1 and dload=0 when wb_en=1.
- Load extract:
  - Byte lane is addr[1:0]; half uses addr[1].
  - Sign-extend unless ex_mem_unsigned. Word is passed through.
- Store:
  - byte: wdata={4{b}}, strb=1<<addr[1:0].
  - half: wdata={2{h}}, strb=addr[1]?4'b1100:4'b0011.
  - word: strb=4'b1111.
  - Loads drive strb=0.
- Latch update priority: rst > wb_flush (all fields to 0) > (wb_en & !mem_stall) loads the new values > hold.
- wb_flush does not abort an in-flight access. The FSM still finishes it, but the flushed cycle's result is discarded.
- Non-memory instructions pass through in one cycle with dload=0. Total latency is 1 cycle plus bus wait cycles.

Decomposition:
- common_types_pkg:
  - mem_size_t enum (BYTE, HALF, WORD).
  - mem_state_t enum (IDLE, WAIT, HOLD).
  - reg_wr_src encodings as named constants.
- One combinational sub-module, load_store_align: inputs addr[1:0], size, unsigned, store data and rdata; outputs wdata, strb and the extended load value.
- FSM, timeout counter, hold register and the latch stay in memory_stage.

Test Plan:
- Zero-wait load: lb at 0x1003, unsigned=0, rdata=0x80FF_FF12, ready same cycle -> mem_stall=0, wb_dload=0xFFFF_FF80, wb_reg_wr_src=1 the next cycle.
- 3-wait store: sh 0xBEEF to 0x2002 -> dbus_strb=4'b1100, wdata=0xBEEF_BEEF, addr stable for 4 cycles, mem_stall=1 for exactly 3 cycles, one request only.
- Ready with wb_en=0: lw 0x3000 with rdata=0x1234_5678 while wb_en=0 for 2 cycles -> FSM goes to HOLD with no re-request; wb_dload=0x1234_5678 after wb_en rises.
- Misaligned lw at 0x4001 -> dbus_req stays 0, mem_fault pulses for 1 cycle, wb_halt=1.
- Timeout with BUS_TIMEOUT=4 and ready never asserted -> req drops after 4 WAIT cycles, mem_fault=1, wb_halt=1, wb_dload=0.
- Flush and reset: wb_flush during a stalled load -> wb_* all 0 for that cycle; rst during WAIT -> dbus_req=0 and wb_* all 0 the next cycle.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared types for the memory stage.
//   mem_size_t  : access width encoding carried on ex_mem_size
//   mem_state_t : bus FSM states (IDLE, WAIT, HOLD)
//   wb_latch_t  : contents of the memory-to-writeback pipeline register
//   WB_SRC_*    : reg_wr_src encodings
//   addr_misaligned() : alignment rule for a given access width
package common_types_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } mem_state_t;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] WB_SRC_PC4 = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic        halt;
    logic [4:0]  rd;
    logic [1:0]  reg_wr_src;
    logic [31:0] alu_out;
    logic [31:0] dload;
  } wb_latch_t;

  // Halves must sit on even addresses, words on multiples of four.
  // The unused size encoding 3 is treated as a word.
  function automatic logic addr_misaligned(input mem_size_t size,
                                           input logic [1:0] addr_lo);
    logic r;
    case (size)
      BYTE:    r = 1'b0;
      HALF:    r = addr_lo[0];
      default: r = |addr_lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering between the core and a 32-bit data bus.
//   addr_i       : low two address bits (byte lane)
//   size_i       : access width
//   unsigned_i   : zero-extend loads when set
//   store_data_i : rs2 value to be written
//   rdata_i      : raw bus read word
//   wdata_o      : store data replicated across all lanes of its width
//   strb_o       : byte strobes for a store of this width/address
//   load_o       : selected and extended load value
module load_store_align
  import common_types_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  strb_o,
  output logic [31:0] load_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = 8'h00;
    case (addr_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    // Halves only ever start on lane 0 or lane 2.
    ld_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    wdata_o = '0;
    strb_o  = '0;
    load_o  = '0;
    case (size_i)
      BYTE: begin
        load_o  = {{24{ld_byte[7] & ~unsigned_i}}, ld_byte};
        wdata_o = {4{store_data_i[7:0]}};
        strb_o  = 4'b0001 << addr_i;
      end
      HALF: begin
        load_o  = {{16{ld_half[15] & ~unsigned_i}}, ld_half};
        wdata_o = {2{store_data_i[15:0]}};
        strb_o  = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        load_o  = rdata_i;
        wdata_o = store_data_i;
        strb_o  = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: runs the load/store held in the execute-to-memory latch on a
// req/ready data bus, then fills the memory-to-writeback latch.
//
// Bus handshake: dbus_req is raised while an access is outstanding and, once
// raised, address/wen/wdata/strb stay constant until the cycle dbus_ready is
// seen with dbus_req high; that cycle completes the access. dbus_rdata is only
// looked at in that cycle. The stage never drops a raised request except on
// timeout or reset.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   ex_*              : current instruction from the execute latch
//   wb_en, wb_flush   : writeback latch enable / clear from the hazard unit
//   dbus_*            : data bus master side
//   mem_stall         : hold upstream stages while an access is outstanding
//   mem_fault         : one-cycle pulse on misaligned access or bus timeout
//   wb_*              : writeback latch contents
//   dbg_state         : current bus FSM state
//
// BUS_TIMEOUT is the number of WAIT cycles allowed before the access is
// abandoned (0 waits forever).
module memory_stage
  import common_types_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_pc,
  input  logic        ex_halt,
  input  logic [4:0]  ex_rd,
  input  logic [1:0]  ex_reg_wr_src,
  input  logic [31:0] ex_alu_out,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_unsigned,
  input  logic [31:0] ex_store_data,
  input  logic        wb_en,
  input  logic        wb_flush,
  output logic        dbus_req,
  output logic        dbus_wen,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_strb,
  input  logic        dbus_ready,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [31:0] wb_pc,
  output logic        wb_halt,
  output logic [4:0]  wb_rd,
  output logic [1:0]  wb_reg_wr_src,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_dload,
  output mem_state_t  dbg_state
);

  localparam int CNT_W = (BUS_TIMEOUT < 1) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(BUS_TIMEOUT);
  localparam bit TIMEOUT_EN = (BUS_TIMEOUT != 0);

  // Instruction decode
  mem_size_t size_e;
  logic      access;
  logic      is_load;
  logic      is_store;
  logic      misaligned;

  assign size_e     = mem_size_t'(ex_mem_size);
  assign access     = ex_mem_rd | ex_mem_wr;
  // A request with both rd and wr set is a load.
  assign is_load    = ex_mem_rd;
  assign is_store   = ex_mem_wr & ~ex_mem_rd;
  assign misaligned = access & addr_misaligned(size_e, ex_alu_out[1:0]);

  // Lane steering
  logic [31:0] align_wdata;
  logic [3:0]  align_strb;
  logic [31:0] load_ext;

  load_store_align u_align (
    .addr_i       (ex_alu_out[1:0]),
    .size_i       (size_e),
    .unsigned_i   (ex_mem_unsigned),
    .store_data_i (ex_store_data),
    .rdata_i      (dbus_rdata),
    .wdata_o      (align_wdata),
    .strb_o       (align_strb),
    .load_o       (load_ext)
  );

  assign dbus_addr  = {ex_alu_out[31:2], 2'b00};
  assign dbus_wdata = align_wdata;
  assign dbus_strb  = is_store ? align_strb : 4'b0000;
  assign dbus_wen   = dbus_req & is_store;

  // FSM, timeout counter and hold register
  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hold_dload_q, hold_dload_d;
  logic             hold_fault_q, hold_fault_d;

  logic        done;       // access (or its fault) resolves this cycle
  logic        fault_now;  // this cycle's completion is a fault
  logic [31:0] dload_now;  // load value produced by this cycle's completion
  logic        timeout_hit;

  assign timeout_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_CNT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    hold_dload_d = hold_dload_q;
    hold_fault_d = hold_fault_q;
    dbus_req     = 1'b0;
    mem_stall    = 1'b0;
    mem_fault    = 1'b0;
    done         = 1'b0;
    fault_now    = 1'b0;
    dload_now    = '0;

    case (state_q)
      IDLE: begin
        if (misaligned) begin
          // Never reaches the bus; resolves immediately as a halting fault.
          mem_fault = 1'b1;
          fault_now = 1'b1;
          done      = 1'b1;
        end else if (access) begin
          dbus_req = 1'b1;
          if (dbus_ready) begin
            done = 1'b1;
            if (is_load) dload_now = load_ext;
          end else begin
            mem_stall = 1'b1;
            state_d   = WAIT;
          end
        end
      end

      WAIT: begin
        if (timeout_hit) begin
          // Request is withdrawn; a late ready in this cycle is ignored.
          mem_fault = 1'b1;
          fault_now = 1'b1;
          done      = 1'b1;
        end else begin
          dbus_req = 1'b1;
          if (dbus_ready) begin
            done = 1'b1;
            if (is_load) dload_now = load_ext;
          end else begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
      end

      HOLD: begin
        // Result already captured; wait for the latch to take it.
        if (wb_en) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A finished access that the latch cannot take yet is parked in HOLD so
    // that the still-present instruction is not sent to the bus again.
    if (done) begin
      if (wb_en) begin
        state_d = IDLE;
      end else begin
        state_d      = HOLD;
        hold_dload_d = dload_now;
        hold_fault_d = fault_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_dload_q <= '0;
      hold_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_dload_q <= hold_dload_d;
      hold_fault_q <= hold_fault_d;
    end
  end

  // Writeback latch
  wb_latch_t latch_q, latch_d, latch_new;

  always_comb begin
    latch_new            = '0;
    latch_new.pc         = ex_pc;
    latch_new.rd         = ex_rd;
    latch_new.reg_wr_src = ex_reg_wr_src;
    latch_new.alu_out    = ex_alu_out;
    if (state_q == HOLD) begin
      latch_new.halt  = ex_halt | hold_fault_q;
      latch_new.dload = hold_dload_q;
    end else begin
      latch_new.halt  = ex_halt | fault_now;
      latch_new.dload = dload_now;
    end

    latch_d = latch_q;
    if (wb_flush) begin
      latch_d = '0;
    end else if (wb_en && !mem_stall) begin
      latch_d = latch_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q <= '0;
    end else begin
      latch_q <= latch_d;
    end
  end

  assign wb_pc         = latch_q.pc;
  assign wb_halt       = latch_q.halt;
  assign wb_rd         = latch_q.rd;
  assign wb_reg_wr_src = latch_q.reg_wr_src;
  assign wb_alu_out    = latch_q.alu_out;
  assign wb_dload      = latch_q.dload;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage with BUS_TIMEOUT = 4.
module tb_memory_stage;
  import common_types_pkg::*;

  localparam int TO = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] ex_pc, ex_alu_out, ex_store_data, dbus_addr, dbus_wdata, dbus_rdata;
  logic        ex_halt, ex_mem_rd, ex_mem_wr, ex_mem_unsigned, wb_en, wb_flush;
  logic [4:0]  ex_rd, wb_rd;
  logic [1:0]  ex_reg_wr_src, ex_mem_size, wb_reg_wr_src;
  logic        dbus_req, dbus_wen, dbus_ready, mem_stall, mem_fault, wb_halt;
  logic [3:0]  dbus_strb;
  logic [31:0] wb_pc, wb_alu_out, wb_dload;
  mem_state_t  dbg_state;

  memory_stage #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_pc(ex_pc), .ex_halt(ex_halt), .ex_rd(ex_rd), .ex_reg_wr_src(ex_reg_wr_src),
    .ex_alu_out(ex_alu_out), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_store_data(ex_store_data), .wb_en(wb_en), .wb_flush(wb_flush),
    .dbus_req(dbus_req), .dbus_wen(dbus_wen), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_strb(dbus_strb), .dbus_ready(dbus_ready),
    .dbus_rdata(dbus_rdata), .mem_stall(mem_stall), .mem_fault(mem_fault),
    .wb_pc(wb_pc), .wb_halt(wb_halt), .wb_rd(wb_rd), .wb_reg_wr_src(wb_reg_wr_src),
    .wb_alu_out(wb_alu_out), .wb_dload(wb_dload), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [31:0] pc;
    logic        halt;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] alu;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] sd;
  } instr_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic        ld;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic [31:0] exp_dload;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  // Scoreboard
  int total = 0;
  int bad   = 0;
  logic [103:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] a,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (rdata >> (8 * a)) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (rdata >> (16 * a[1])) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] sd, input logic [1:0] size);
    if (size == 2'd0) return {24'h0, sd[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'h0, sd[15:0]} * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] a, input logic [1:0] size);
    if (size == 2'd0) return 4'd1 << a;
    if (size == 2'd1) return 4'd3 << (2 * a[1]);
    return 4'hF;
  endfunction

  function automatic logic model_mis(input logic [1:0] a, input logic [1:0] size);
    return (size == 2'd1 && a[0]) || (size == 2'd2 && a != 2'd0);
  endfunction

  // Driver tasks
  task automatic drive_instr(input instr_t ins);
    ex_pc           = ins.pc;
    ex_halt         = ins.halt;
    ex_rd           = ins.rd;
    ex_reg_wr_src   = ins.src;
    ex_alu_out      = ins.alu;
    ex_mem_rd       = ins.rd_en;
    ex_mem_wr       = ins.wr_en;
    ex_mem_size     = ins.size;
    ex_mem_unsigned = ins.uns;
    ex_store_data   = ins.sd;
  endtask

  task automatic clear_instr();
    ex_pc = '0; ex_halt = 1'b0; ex_rd = '0; ex_reg_wr_src = '0; ex_alu_out = '0;
    ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_mem_size = '0; ex_mem_unsigned = 1'b0;
    ex_store_data = '0;
  endtask

  function automatic logic [103:0] wb_now();
    return {wb_pc, wb_halt, wb_rd, wb_reg_wr_src, wb_alu_out, wb_dload};
  endfunction

  // Runs one instruction to writeback acceptance. The bus answers after
  // wait_n request cycles (never if wait_n exceeds the timeout window), and
  // wb_en stays low for en_hold cycles once the access has resolved.
  // Called and returns 1 time unit after a rising edge.
  task automatic run_instr(input instr_t ins, input int wait_n, input int en_hold,
                           input logic [31:0] rdata);
    logic acc, ld, st, mis, aligned, tmo, fault, accepted, exp_req;
    int done_c, c;
    logic [31:0] dl;
    mem_state_t exp_st;
    acc     = ins.rd_en | ins.wr_en;
    ld      = ins.rd_en;
    st      = ins.wr_en & !ins.rd_en;
    mis     = acc && model_mis(ins.alu[1:0], ins.size);
    aligned = acc && !mis;
    tmo     = aligned && (wait_n > TO);
    fault   = mis || tmo;
    if (!aligned) done_c = 0;
    else if (tmo) done_c = TO + 1;
    else done_c = wait_n;
    dl = (ld && !fault) ? model_load(rdata, ins.alu[1:0], ins.size, ins.uns) : 32'h0;
    exp_q.push_back({ins.pc, ins.halt | fault, ins.rd, ins.src, ins.alu, dl});

    drive_instr(ins);
    dbus_rdata = rdata;
    c = 0;
    accepted = 1'b0;
    while (!accepted && c < 64) begin
      if (c >= done_c + en_hold) wb_en = 1'b1;
      else if (c < done_c) wb_en = 1'($urandom_range(0, 1));
      else wb_en = 1'b0;
      dbus_ready = aligned && !tmo && (c == wait_n);
      @(negedge clk);
      exp_req = aligned && (c < done_c || (c == done_c && !tmo));
      chk("dbus_req", dbus_req, exp_req);
      chk("mem_stall", mem_stall, aligned && c < done_c);
      chk("mem_fault", mem_fault, fault && c == done_c);
      if (!acc || c == 0) exp_st = IDLE;
      else if (c > done_c) exp_st = HOLD;
      else exp_st = WAIT;
      chk("state", dbg_state, exp_st);
      if (exp_req) begin
        chk("dbus_addr", dbus_addr, {ins.alu[31:2], 2'b00});
        chk("dbus_wen", dbus_wen, st);
        chk("dbus_strb", dbus_strb, st ? model_strb(ins.alu[1:0], ins.size) : 4'h0);
        if (st) chk("dbus_wdata", dbus_wdata, model_wdata(ins.sd, ins.size));
      end
      accepted = wb_en && (c >= done_c);
      @(posedge clk);
      #1;
      c++;
    end
    dbus_ready = 1'b0;
    if (accepted) begin
      chk("wb_latch", wb_now(), exp_q.pop_front());
    end else begin
      total++;
      bad++;
      $display("FAIL accept_bound: instruction pc=%0h not accepted within 64 cycles", ins.pc);
      void'(exp_q.pop_front());
    end
  endtask

  vec_t   vecs[11];
  instr_t ins;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait vectors: {addr, size, uns, ld, sd, rdata, dload, strb, wdata}
    vecs[0]  = '{32'h1003, 2'd0, 1'b0, 1'b1, 32'h0, 32'h80FF_FF12, 32'hFFFF_FF80, 4'h0, 32'h0};
    vecs[1]  = '{32'h1003, 2'd0, 1'b1, 1'b1, 32'h0, 32'h80FF_FF12, 32'h0000_0080, 4'h0, 32'h0};
    vecs[2]  = '{32'h1001, 2'd0, 1'b0, 1'b1, 32'h0, 32'h80FF_FF12, 32'hFFFF_FFFF, 4'h0, 32'h0};
    vecs[3]  = '{32'h1002, 2'd1, 1'b0, 1'b1, 32'h0, 32'h80FF_FF12, 32'hFFFF_80FF, 4'h0, 32'h0};
    vecs[4]  = '{32'h1000, 2'd1, 1'b1, 1'b1, 32'h0, 32'h1234_F00D, 32'h0000_F00D, 4'h0, 32'h0};
    vecs[5]  = '{32'h1000, 2'd1, 1'b0, 1'b1, 32'h0, 32'h1234_F00D, 32'hFFFF_F00D, 4'h0, 32'h0};
    vecs[6]  = '{32'h1004, 2'd2, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'h0, 32'h0};
    vecs[7]  = '{32'h1002, 2'd0, 1'b0, 1'b0, 32'h1234_56A5, 32'h0, 32'h0, 4'b0100, 32'hA5A5_A5A5};
    vecs[8]  = '{32'h1000, 2'd1, 1'b0, 1'b0, 32'h0000_BEEF, 32'h0, 32'h0, 4'b0011, 32'hBEEF_BEEF};
    vecs[9]  = '{32'h1008, 2'd2, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0, 32'h0, 4'b1111, 32'hCAFE_F00D};
    vecs[10] = '{32'h1003, 2'd0, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 32'h0, 4'b1000, 32'h7777_7777};

    // Reset
    rst = 1'b1;
    clear_instr();
    wb_en = 1'b1;
    wb_flush = 1'b0;
    dbus_ready = 1'b0;
    dbus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wb", wb_now(), 104'h0);
    chk("reset_req", dbus_req, 1'b0);
    chk("reset_fault", mem_fault, 1'b0);
    chk("reset_stall", mem_stall, 1'b0);
    chk("reset_state", dbg_state, IDLE);
    rst = 1'b0;

    // Zero-wait table
    for (int i = 0; i < 11; i++) begin
      ins.pc    = 32'h0000_0100 + 32'(i * 4);
      ins.halt  = 1'b0;
      ins.rd    = 5'(i + 1);
      ins.src   = vecs[i].ld ? WB_SRC_MEM : WB_SRC_ALU;
      ins.alu   = vecs[i].addr;
      ins.rd_en = vecs[i].ld;
      ins.wr_en = !vecs[i].ld;
      ins.size  = vecs[i].size;
      ins.uns   = vecs[i].uns;
      ins.sd    = vecs[i].sd;
      drive_instr(ins);
      dbus_rdata = vecs[i].rdata;
      dbus_ready = 1'b1;
      wb_en = 1'b1;
      @(negedge clk);
      chk("vec_req", dbus_req, 1'b1);
      chk("vec_stall", mem_stall, 1'b0);
      chk("vec_strb", dbus_strb, vecs[i].exp_strb);
      if (!vecs[i].ld) chk("vec_wdata", dbus_wdata, vecs[i].exp_wdata);
      @(posedge clk);
      #1;
      chk("vec_dload", wb_dload, vecs[i].exp_dload);
      chk("vec_src", wb_reg_wr_src, vecs[i].ld ? WB_SRC_MEM : WB_SRC_ALU);
    end
    dbus_ready = 1'b0;

    // 3-wait halfword store
    ins = '{32'h200, 1'b0, 5'd0, WB_SRC_ALU, 32'h2002, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF};
    run_instr(ins, 3, 0, 32'h0);
    // Completion while the latch is blocked -> HOLD
    ins = '{32'h300, 1'b0, 5'd9, WB_SRC_MEM, 32'h3000, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0};
    run_instr(ins, 0, 2, 32'h1234_5678);
    // Misaligned word load, then misaligned half store parked in HOLD
    ins = '{32'h400, 1'b0, 5'd3, WB_SRC_MEM, 32'h4001, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0};
    run_instr(ins, 0, 0, 32'hFFFF_FFFF);
    ins = '{32'h404, 1'b0, 5'd0, WB_SRC_ALU, 32'h4003, 1'b0, 1'b1, 2'd1, 1'b0, 32'h55};
    run_instr(ins, 0, 1, 32'h0);
    // Timeouts, then a non-memory op and a pc+4 op
    ins = '{32'h410, 1'b0, 5'd4, WB_SRC_MEM, 32'h4100, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0};
    run_instr(ins, 99, 0, 32'hABCD_EF01);
    ins = '{32'h414, 1'b0, 5'd0, WB_SRC_ALU, 32'h4104, 1'b0, 1'b1, 2'd2, 1'b0, 32'h1};
    run_instr(ins, 99, 2, 32'h0);
    ins = '{32'h418, 1'b0, 5'd5, WB_SRC_PC4, 32'h0000_041C, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0};
    run_instr(ins, 0, 1, 32'h0);
    ins = '{32'h41C, 1'b0, 5'd0, WB_SRC_ALU, 32'h4108, 1'b0, 1'b1, 2'd2, 1'b0, 32'h7};
    run_instr(ins, TO, 0, 32'h0);

    // Flush during a stalled load
    ins = '{32'h500, 1'b0, 5'd7, WB_SRC_MEM, 32'h5000, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0};
    drive_instr(ins);
    dbus_rdata = 32'hA5A5_0001;
    wb_en = 1'b1;
    @(negedge clk);
    chk("flush_req0", dbus_req, 1'b1);
    @(posedge clk);
    #1;
    wb_flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", mem_stall, 1'b1);
    @(posedge clk);
    #1;
    chk("flush_wb", wb_now(), 104'h0);
    chk("flush_state", dbg_state, WAIT);
    wb_flush = 1'b0;
    dbus_ready = 1'b1;
    @(negedge clk);
    chk("flush_req2", dbus_req, 1'b1);
    @(posedge clk);
    #1;
    dbus_ready = 1'b0;
    chk("flush_done", wb_now(), {32'h500, 1'b0, 5'd7, WB_SRC_MEM, 32'h5000, 32'hA5A5_0001});

    // Reset during WAIT
    ins = '{32'h600, 1'b0, 5'd8, WB_SRC_MEM, 32'h6000, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0};
    drive_instr(ins);
    @(negedge clk);
    chk("rstw_req0", dbus_req, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_instr();
    @(posedge clk);
    #1;
    chk("rstw_req", dbus_req, 1'b0);
    chk("rstw_fault", mem_fault, 1'b0);
    chk("rstw_state", dbg_state, IDLE);
    chk("rstw_wb", wb_now(), 104'h0);
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      int kind, wait_n, en_hold;
      kind      = $urandom_range(0, 3);
      ins.pc    = $urandom & 32'hFFFF_FFFC;
      ins.halt  = ($urandom_range(0, 9) == 0);
      ins.rd    = 5'($urandom_range(0, 31));
      ins.src   = 2'($urandom_range(0, 2));
      ins.alu   = $urandom;
      if ($urandom_range(0, 1) == 1) ins.alu[1:0] = 2'b00;
      ins.rd_en = (kind == 1 || kind == 3);
      ins.wr_en = (kind == 2 || kind == 3);
      ins.size  = 2'($urandom_range(0, 2));
      ins.uns   = 1'($urandom_range(0, 1));
      ins.sd    = $urandom;
      wait_n    = $urandom_range(0, 6);
      en_hold   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_instr(ins, wait_n, en_hold, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
